// File: rtl/issue_select_pkg.sv
// Shared issue-side types: issue packet, RS entry layout and the ROB-age ordering helper.
// Pure declarations; no latency or flow control of its own.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 3
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif
`ifndef PRF_WIDTH
`define PRF_WIDTH 6
`endif

package issue_select_pkg;

    localparam int ISSUE_W  = `ISSUE_WIDTH;
    localparam int ROB_W    = `ROB_WIDTH;
    localparam int PRF_W    = `PRF_WIDTH;
    localparam int AGE_BITS = `ROB_WIDTH + 1;
    localparam int FU_ID_W  = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
    localparam int IMM_W    = 16;

    typedef struct packed {
        logic               packet_valid;
        logic [FU_ID_W-1:0] fu_id;
        logic [ROB_W-1:0]   rob_entry;
        logic [PRF_W-1:0]   dest_prf;
        logic [PRF_W-1:0]   src1_prf;
        logic [PRF_W-1:0]   src2_prf;
        logic [IMM_W-1:0]   imm;
    } ISSUE_PACKET;

    typedef struct packed {
        logic                valid;
        logic [ISSUE_W-1:0]  wake_up;
        logic                issued;
        logic [AGE_BITS-1:0] age;
        ISSUE_PACKET         pkt;
    } RS_ENTRY;

    // MSB is the ROB wrap bit: once the wrap bits differ, the larger index was allocated first.
    function automatic logic age_older(input logic [AGE_BITS-1:0] a,
                                       input logic [AGE_BITS-1:0] b);
        logic same_wrap;
        same_wrap = (a[AGE_BITS-1] == b[AGE_BITS-1]);
        if (same_wrap)
            return a[AGE_BITS-2:0] < b[AGE_BITS-2:0];
        else
            return a[AGE_BITS-2:0] > b[AGE_BITS-2:0];
    endfunction

endpackage

// File: rtl/issue_select_age_select.sv
// Oldest-first selection tree: request vector plus ages in, one-hot grant plus valid out.
// Purely combinational; no flow control, the caller qualifies the grant.
module age_select
    import issue_select_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]               i_req,
    input  logic [N-1:0][AGE_BITS-1:0] i_age,
    output logic [N-1:0]               o_grant,
    output logic                       o_vld
);

    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int LEAVES = 1 << IDX_W;

    always_comb begin : p_tree
        logic                w_vld [1:2*LEAVES-1];
        logic [IDX_W-1:0]    w_idx [1:2*LEAVES-1];
        logic [AGE_BITS-1:0] w_age [1:2*LEAVES-1];

        for (int n = 1; n < 2*LEAVES; n++) begin
            w_vld[n] = 1'b0;
            w_idx[n] = '0;
            w_age[n] = '0;
        end
        for (int i = 0; i < LEAVES; i++) begin
            if (i < N) begin
                w_vld[LEAVES+i] = i_req[i];
                w_idx[LEAVES+i] = IDX_W'(i);
                w_age[LEAVES+i] = i_age[i];
            end
        end
        // Left subtree holds the lower indices, so it keeps the win on equal ages.
        for (int n = LEAVES-1; n >= 1; n--) begin
            if (w_vld[2*n+1] && (!w_vld[2*n] || age_older(w_age[2*n+1], w_age[2*n]))) begin
                w_idx[n] = w_idx[2*n+1];
                w_age[n] = w_age[2*n+1];
            end else begin
                w_idx[n] = w_idx[2*n];
                w_age[n] = w_age[2*n];
            end
            w_vld[n] = w_vld[2*n] | w_vld[2*n+1];
        end

        o_vld   = w_vld[1];
        o_grant = '0;
        for (int i = 0; i < N; i++)
            o_grant[i] = w_vld[1] && (w_idx[1] == IDX_W'(i));
    end

endmodule

// File: rtl/issue_select.sv
// Picks the oldest ready RS entry per FU and registers it into a per-FU valid/ready output stage.
// Grant is same-cycle, packet appears one cycle later; a stalled stage withholds grants for its FU.
module issue_select
    import issue_select_pkg::*;
#(
    parameter int NUM_RS      = 8,
    parameter int ISSUE_WIDTH = `ISSUE_WIDTH,
    parameter int AGE_W       = `ROB_WIDTH + 1,
    parameter int CNT_W       = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 pipe_flush,
    input  logic [NUM_RS-1:0][ISSUE_WIDTH-1:0]   rs_wake_up,
    input  logic [NUM_RS-1:0]                    rs_issued,
    input  logic [NUM_RS-1:0][AGE_W-1:0]         rs_age,
    input  ISSUE_PACKET [NUM_RS-1:0]             rs_issue_pkt,
    input  logic [ISSUE_WIDTH-1:0]               fu_ready,
    output logic [NUM_RS-1:0]                    issue_en,
    output logic [ISSUE_WIDTH-1:0]               issue_valid,
    output ISSUE_PACKET [ISSUE_WIDTH-1:0]        issue_pkt,
    output logic [ISSUE_WIDTH-1:0][CNT_W-1:0]    issue_cnt
);

    logic [ISSUE_WIDTH-1:0][NUM_RS-1:0] w_req;
    logic [ISSUE_WIDTH-1:0][NUM_RS-1:0] w_grant;
    logic [ISSUE_WIDTH-1:0]             w_sel_vld;
    logic [ISSUE_WIDTH-1:0]             w_can_accept;
    logic [ISSUE_WIDTH-1:0]             w_fu_grant;
    logic [ISSUE_WIDTH-1:0]             w_pop;
    ISSUE_PACKET [ISSUE_WIDTH-1:0]      w_sel_pkt;

    logic [ISSUE_WIDTH-1:0]             r_valid;
    ISSUE_PACKET [ISSUE_WIDTH-1:0]      r_pkt;
    logic [ISSUE_WIDTH-1:0][CNT_W-1:0]  r_cnt;

    always_comb begin
        w_req = '0;
        for (int f = 0; f < ISSUE_WIDTH; f++)
            for (int i = 0; i < NUM_RS; i++)
                w_req[f][i] = rs_wake_up[i][f] & ~rs_issued[i];
    end

    for (genvar f = 0; f < ISSUE_WIDTH; f++) begin : g_fu
        age_select #(
            .N (NUM_RS)
        ) u_age_select (
            .i_req   (w_req[f]),
            .i_age   (rs_age),
            .o_grant (w_grant[f]),
            .o_vld   (w_sel_vld[f])
        );
    end

    // rst_n gates the grant so no entry frees itself while the stage is held in reset.
    always_comb begin
        w_can_accept = '0;
        w_fu_grant   = '0;
        w_pop        = '0;
        w_sel_pkt    = '0;
        issue_en     = '0;
        for (int f = 0; f < ISSUE_WIDTH; f++) begin
            w_can_accept[f] = ~r_valid[f] | fu_ready[f];
            w_fu_grant[f]   = w_sel_vld[f] & w_can_accept[f] & ~pipe_flush & rst_n;
            w_pop[f]        = r_valid[f] & fu_ready[f] & ~pipe_flush;
            for (int i = 0; i < NUM_RS; i++) begin
                if (w_grant[f][i])
                    w_sel_pkt[f] = ISSUE_PACKET'(w_sel_pkt[f] | rs_issue_pkt[i]);
                issue_en[i] = issue_en[i] | (w_grant[f][i] & w_fu_grant[f]);
            end
            w_sel_pkt[f].packet_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_pkt   <= '0;
            r_cnt   <= '0;
        end else begin
            for (int f = 0; f < ISSUE_WIDTH; f++) begin
                if (pipe_flush)
                    r_valid[f] <= 1'b0;
                else if (w_fu_grant[f]) begin
                    r_valid[f] <= 1'b1;
                    r_pkt[f]   <= w_sel_pkt[f];
                end else if (w_pop[f])
                    r_valid[f] <= 1'b0;

                if (w_pop[f] && (r_cnt[f] != '1))
                    r_cnt[f] <= r_cnt[f] + CNT_W'(1);
            end
        end
    end

    assign issue_valid = r_valid;
    assign issue_pkt   = r_pkt;
    assign issue_cnt   = r_cnt;

endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select: vector table of selection cases plus stall, flush and reset sequences,
// with a packet scoreboard and a small model of the per-FU output stage and counters.
module tb_issue_select;
    import issue_select_pkg::*;

    localparam int NRS = 8;
    localparam int IW  = ISSUE_W;
    localparam int AW  = AGE_BITS;
    localparam int CW  = 32;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       d_flush;
    logic [NRS-1:0][IW-1:0]     d_wake;
    logic [NRS-1:0]             d_issued;
    logic [NRS-1:0][AW-1:0]     d_age;
    ISSUE_PACKET [NRS-1:0]      d_pkt;
    logic [IW-1:0]              d_fu_ready;
    logic [NRS-1:0]             issue_en;
    logic [IW-1:0]              issue_valid;
    ISSUE_PACKET [IW-1:0]       issue_pkt;
    logic [IW-1:0][CW-1:0]      issue_cnt;

    always #5 clk = ~clk;

    issue_select #(
        .NUM_RS      (NRS),
        .ISSUE_WIDTH (IW),
        .AGE_W       (AW),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_flush   (d_flush),
        .rs_wake_up   (d_wake),
        .rs_issued    (d_issued),
        .rs_age       (d_age),
        .rs_issue_pkt (d_pkt),
        .fu_ready     (d_fu_ready),
        .issue_en     (issue_en),
        .issue_valid  (issue_valid),
        .issue_pkt    (issue_pkt),
        .issue_cnt    (issue_cnt)
    );

    typedef struct packed {
        logic [2:0]          act;
        logic [2:0][2:0]     idx;
        logic [2:0][1:0]     fu;
        logic [2:0][AW-1:0]  age;
        logic [NRS-1:0]      issued;
        logic [NRS-1:0]      exp_en;
    } vec_t;

    typedef struct packed {
        logic [1:0]  fu;
        ISSUE_PACKET pkt;
    } sb_item_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [IW-1:0] m_valid;
    ISSUE_PACKET   m_pkt [IW];
    logic [CW-1:0] m_cnt [IW];
    sb_item_t      sb_q [$];
    vec_t          vecs [11];

    always @(negedge clk) begin
        if (rst_n)
            for (int i = 0; i < NRS; i++)
                assert ($countones(d_wake[i]) <= 1)
                else $error("illegal multi-wake on entry %0d", i);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] act,
                                 input int i0, input int f0, input logic [AW-1:0] a0,
                                 input int i1, input int f1, input logic [AW-1:0] a1,
                                 input int i2, input int f2, input logic [AW-1:0] a2,
                                 input logic [NRS-1:0] issued, input logic [NRS-1:0] exp_en);
        vec_t v;
        v.act    = act;
        v.idx[0] = 3'(i0); v.fu[0] = 2'(f0); v.age[0] = a0;
        v.idx[1] = 3'(i1); v.fu[1] = 2'(f1); v.age[1] = a1;
        v.idx[2] = 3'(i2); v.fu[2] = 2'(f2); v.age[2] = a2;
        v.issued = issued;
        v.exp_en = exp_en;
        return v;
    endfunction

    task automatic build(input vec_t v);
        d_wake   = '0;
        d_issued = v.issued;
        for (int i = 0; i < NRS; i++)
            d_age[i] = AW'(8'h10 + i);
        for (int k = 0; k < 3; k++)
            if (v.act[k]) begin
                d_wake[v.idx[k]][v.fu[k]] = 1'b1;
                d_age[v.idx[k]]           = v.age[k];
            end
        for (int i = 0; i < NRS; i++) begin
            d_pkt[i]              = '0;
            d_pkt[i].packet_valid = 1'b0;
            for (int f = 0; f < IW; f++)
                if (d_wake[i][f]) d_pkt[i].fu_id = FU_ID_W'(f);
            d_pkt[i].rob_entry = d_age[i][ROB_W-1:0];
            d_pkt[i].dest_prf  = PRF_W'(i);
            d_pkt[i].src1_prf  = PRF_W'(i + 8);
            d_pkt[i].src2_prf  = PRF_W'(i + 16);
            d_pkt[i].imm       = 16'hA500 + 16'(i);
        end
    endtask

    // Called at posedge+1; checks the grant mid-cycle, then the registered stage after the edge.
    task automatic step(input logic [NRS-1:0] exp_en, input string name);
        logic [IW-1:0] gnt;
        logic [IW-1:0] pop;
        ISSUE_PACKET   ep;
        sb_item_t      item;
        @(negedge clk);
        check({name, " issue_en"}, 64'(issue_en), 64'(exp_en));
        gnt = '0;
        for (int f = 0; f < IW; f++)
            for (int i = 0; i < NRS; i++)
                if (exp_en[i] && d_wake[i][f]) begin
                    gnt[f]          = 1'b1;
                    ep              = d_pkt[i];
                    ep.packet_valid = 1'b1;
                    sb_q.push_back('{fu: 2'(f), pkt: ep});
                end
        pop = m_valid & d_fu_ready & ~{IW{d_flush}};
        @(posedge clk);
        #1;
        for (int f = 0; f < IW; f++) begin
            if (pop[f] && (m_cnt[f] != '1)) m_cnt[f] = m_cnt[f] + 1;
            if (d_flush)
                m_valid[f] = 1'b0;
            else if (gnt[f]) begin
                m_valid[f] = 1'b1;
                if (sb_q.size() != 0) begin
                    item     = sb_q.pop_front();
                    m_pkt[f] = item.pkt;
                end
            end else if (pop[f])
                m_valid[f] = 1'b0;
            check($sformatf("%s valid[%0d]", name, f), 64'(issue_valid[f]), 64'(m_valid[f]));
            check($sformatf("%s cnt[%0d]", name, f), 64'(issue_cnt[f]), 64'(m_cnt[f]));
            if (m_valid[f])
                check($sformatf("%s pkt[%0d]", name, f), 64'(issue_pkt[f]), 64'(m_pkt[f]));
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, " issue_en"}, 64'(issue_en), 64'(0));
        check({name, " issue_valid"}, 64'(issue_valid), 64'(0));
        for (int f = 0; f < IW; f++) begin
            check($sformatf("%s pkt[%0d]", name, f), 64'(issue_pkt[f]), 64'(0));
            check($sformatf("%s cnt[%0d]", name, f), 64'(issue_cnt[f]), 64'(0));
        end
    endtask

    task automatic model_reset();
        m_valid = '0;
        for (int f = 0; f < IW; f++) begin
            m_cnt[f] = '0;
            m_pkt[f] = '0;
        end
        sb_q.delete();
    endtask

    initial begin
        vecs[0]  = mkv(3'b001, 3,0,6'h05, 0,0,6'h00, 0,0,6'h00, 8'h00, 8'h08);
        vecs[1]  = mkv(3'b011, 1,1,6'h12, 6,1,6'h07, 0,0,6'h00, 8'h00, 8'h40);
        vecs[2]  = mkv(3'b011, 1,1,6'h12, 6,1,6'h07, 0,0,6'h00, 8'h40, 8'h02);
        vecs[3]  = mkv(3'b011, 2,0,6'h21, 4,0,6'h1E, 0,0,6'h00, 8'h00, 8'h10);
        vecs[4]  = mkv(3'b011, 2,0,6'h21, 4,0,6'h1E, 0,0,6'h00, 8'h10, 8'h04);
        vecs[5]  = mkv(3'b111, 0,0,6'h03, 7,1,6'h04, 5,2,6'h09, 8'h00, 8'hA1);
        vecs[6]  = mkv(3'b011, 2,2,6'h0A, 5,2,6'h0A, 0,0,6'h00, 8'h00, 8'h04);
        vecs[7]  = mkv(3'b001, 3,0,6'h05, 0,0,6'h00, 0,0,6'h00, 8'h08, 8'h00);
        vecs[8]  = mkv(3'b011, 0,0,6'h2F, 7,0,6'h22, 0,0,6'h00, 8'h00, 8'h80);
        vecs[9]  = mkv(3'b011, 1,2,6'h03, 6,2,6'h3F, 0,0,6'h00, 8'h00, 8'h40);
        vecs[10] = mkv(3'b111, 0,1,6'h3C, 3,1,6'h02, 5,1,6'h3E, 8'h00, 8'h01);

        rst_n      = 1'b0;
        d_flush    = 1'b0;
        d_fu_ready = '1;
        model_reset();
        build(mkv(3'b001, 0,0,6'h01, 0,0,6'h00, 0,0,6'h00, 8'h00, 8'h00));
        #12;
        check_all_zero("reset");
        @(negedge clk);
        build(mkv(3'b000, 0,0,6'h00, 0,0,6'h00, 0,0,6'h00, 8'h00, 8'h00));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 11; k++) begin
            build(vecs[k]);
            step(vecs[k].exp_en, $sformatf("vec%0d", k));
        end

        build(mkv(3'b001, 3,0,6'h02, 0,0,6'h00, 0,0,6'h00, 8'h00, 8'h00));
        step(8'h08, "stall_fill");
        d_fu_ready[0] = 1'b0;
        build(mkv(3'b001, 5,0,6'h08, 0,0,6'h00, 0,0,6'h00, 8'h00, 8'h00));
        for (int c = 0; c < 3; c++) step(8'h00, $sformatf("stall%0d", c));
        d_fu_ready = '1;
        step(8'h20, "stall_release");

        build(mkv(3'b001, 4,0,6'h0C, 0,0,6'h00, 0,0,6'h00, 8'h00, 8'h00));
        d_flush = 1'b1;
        step(8'h00, "flush");
        d_flush = 1'b0;
        build(mkv(3'b000, 0,0,6'h00, 0,0,6'h00, 0,0,6'h00, 8'h00, 8'h00));
        step(8'h00, "post_flush");

        build(mkv(3'b001, 2,1,6'h03, 0,0,6'h00, 0,0,6'h00, 8'h00, 8'h00));
        step(8'h04, "rst_fill");
        d_fu_ready[1] = 1'b0;
        build(mkv(3'b001, 6,1,6'h04, 0,0,6'h00, 0,0,6'h00, 8'h00, 8'h00));
        step(8'h00, "rst_stall");
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        @(negedge clk);
        build(mkv(3'b000, 0,0,6'h00, 0,0,6'h00, 0,0,6'h00, 8'h00, 8'h00));
        d_fu_ready = '1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        build(mkv(3'b001, 1,2,6'h07, 0,0,6'h00, 0,0,6'h00, 8'h00, 8'h00));
        step(8'h02, "post_reset");
        build(mkv(3'b000, 0,0,6'h00, 0,0,6'h00, 0,0,6'h00, 8'h00, 8'h00));
        step(8'h00, "drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_select.md
Name: issue_select

Overview:
- Issue-side consumer of the reservation-station entry array: reads every entry's wake-up vector and age, and selects the oldest ready entry per functional unit (FU).
- Drives each entry's issue_en and registers the chosen ISSUE_PACKET into a per-FU output stage with a valid/ready handshake.
- Sits between the RS array and the FU pipelines; per-FU issue counters support performance monitoring.

Parameters:
- NUM_RS, 8, number of RS entries scanned.
- ISSUE_WIDTH, `ISSUE_WIDTH (global), number of FUs / issue ports.
- AGE_W, `ROB_WIDTH+1, age width: ROB index plus MSB wrap bit.
- CNT_W, 32, width of per-FU issue counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pipe_flush  in  1  squash all in-flight issue state.
- rs_wake_up  in  [NUM_RS][ISSUE_WIDTH]  per-entry ready vector; one-hot on that entry's fu_id.
- rs_issued  in  [NUM_RS]  entry already issued; excluded from selection.
- rs_age  in  [NUM_RS][AGE_W]  entry ROB tag with wrap bit.
- rs_issue_pkt  in  ISSUE_PACKET [NUM_RS]  entry payloads.
- fu_ready  in  [ISSUE_WIDTH]  FU accepts the packet held in its output stage.
- issue_en  out  [NUM_RS]  combinational grant to each entry; the entry frees on the next edge.
- issue_valid  out  [ISSUE_WIDTH]  output stage holds a packet.
- issue_pkt  out  ISSUE_PACKET [ISSUE_WIDTH]  registered packet per FU.
- issue_cnt  out  [ISSUE_WIDTH][CNT_W]  packets handed to each FU.

Behaviour:
- Reset (async, rst_n low): issue_valid=0, issue_pkt=0, issue_cnt=0. issue_en=0 while in reset.
- Candidate for FU f: entry i with rs_wake_up[i][f] & ~rs_issued[i].
- Age compare, a older than b:
  - wrap bits equal -> a.idx < b.idx;
  - wrap bits differ -> a.idx > b.idx.
  - Equal ages (illegal) -> lower entry index wins.
- Per FU, the oldest candidate is selected. An entry with more than one wake_up bit set is illegal; the bench asserts against it.
- FU f can accept when ~issue_valid[f] | fu_ready[f].
- issue_en[i] = 1 iff entry i is selected for some f, FU f can accept, and ~pipe_flush. Combinational, same cycle.
- On grant at edge: issue_pkt[f] <= rs_issue_pkt[i] with packet_valid forced to 1; issue_valid[f] <= 1. Select-to-FU latency is one cycle.
- No grant but fu_ready[f] & issue_valid[f]: issue_valid[f] <= 0.
- issue_valid[f] & ~fu_ready[f]: packet and valid hold stable, and no new grant is made to FU f (stall back-pressures the RS).
- Grant with simultaneous fu_ready pop gives back-to-back issue: one packet per FU per cycle.
- issue_cnt[f] increments when issue_valid[f] & fu_ready[f]; saturates at all-ones.
- pipe_flush: issue_en forced 0 that cycle; all issue_valid <= 0 at the edge; counters unchanged; the handshake in that cycle is not counted.
- Flush has priority over grant and pop. Reset mid-stall clears the stage immediately.
- Entries whose valid bit is low have wake_up=0 by construction; no extra qualification is needed.

Decomposition:
- Shared package: ISSUE_PACKET, RS_ENTRY, `ISSUE_WIDTH, `ROB_WIDTH, `PRF_WIDTH. Add an age_older() function there for reuse by the LSQ and ROB.
- Sub-module age_select: parameterised oldest-first tree over NUM_RS (request vector + ages -> one-hot grant + valid). Instantiated once per FU.

Test Plan:
- Single ready entry 3 for FU0, age 0x05, fu_ready=1 -> issue_en[3]=1 same cycle; next cycle issue_valid[0]=1, issue_pkt[0].rob_entry=0x05, issue_cnt[0]=1 one cycle later.
- Entries 1 (age 0x12) and 6 (age 0x07) both for FU1 -> entry 6 granted; entry 1 granted the following cycle.
- Wrap: entry 2 age {1,0x01}, entry 4 age {0,0x1E} for FU0 -> entry 4 (older) granted first.
- FU0 stalled (fu_ready=0) with issue_valid=1 and entry 5 ready -> issue_en[5]=0 and issue_pkt stable for 3 cycles. fu_ready=1 -> pop and grant of entry 5 in the same cycle.
- Simultaneous ready entries for FU0 and FU1 -> both issue_en set in one cycle; both outputs valid next cycle.
- pipe_flush while issue_valid=1 and entry ready -> issue_en=0, issue_valid=0 next cycle, issue_cnt unchanged. Reset asserted mid-stall -> all outputs 0 asynchronously.
